// File: rtl/instr_encoder_pkg.sv
// Shared types and immediate range limits for the instruction encoder.
package instr_encoder_pkg;

  typedef logic [31:0] instr_t;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_CSR_I = 3'd6
  } instr_format_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_BADFMT   = 2'b11
  } err_code_t;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  typedef struct packed {
    instr_t    instr;
    logic      err;
    err_code_t code;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/instr_encoder_fifo.sv
// Two-entry FIFO buffering encoded words; head is always mem[rp].
module encoder_fifo #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rp];

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields and immediates into 32-bit words, flags
// unrepresentable immediates, and buffers results in a 2-entry FIFO.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  instr_format_t in_fmt,
  input  logic [6:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [11:0]   in_csr,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output instr_t        out_instr,
  output logic          out_err,
  output logic [1:0]    out_err_code,
  output logic [15:0]   err_count
);

  logic signed [31:0] imm_s;
  instr_t             enc_instr;
  err_code_t          enc_code;
  fifo_entry_t        push_entry;
  fifo_entry_t        head;
  logic [ENTRY_W-1:0] head_bits;
  logic [1:0]         fifo_count;
  logic               push;
  logic               pop;

  assign imm_s = in_imm;

  // Priority bad format > misaligned > range falls out of the case/if ordering.
  always_comb begin
    enc_instr = '0;
    enc_code  = ERR_NONE;
    case (in_fmt)
      FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (imm_s < IMM_I_MIN || imm_s > IMM_I_MAX) enc_code = ERR_RANGE;
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (imm_s < IMM_I_MIN || imm_s > IMM_I_MAX) enc_code = ERR_RANGE;
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        if (in_imm[0]) enc_code = ERR_MISALIGN;
        else if (imm_s < IMM_B_MIN || imm_s > IMM_B_MAX) enc_code = ERR_RANGE;
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != '0) enc_code = ERR_RANGE;
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0]) enc_code = ERR_MISALIGN;
        else if (imm_s < IMM_J_MIN || imm_s > IMM_J_MAX) enc_code = ERR_RANGE;
      end
      FMT_CSR_I: begin
        enc_instr = {in_csr, in_imm[4:0], in_funct3, in_rd, in_opcode};
        if (in_imm[31:5] != '0) enc_code = ERR_RANGE;
      end
      default: begin
        enc_instr = '0;
        enc_code  = ERR_BADFMT;
      end
    endcase
  end

  assign push_entry = '{instr: enc_instr, err: (enc_code != ERR_NONE), code: enc_code};

  assign in_ready  = (fifo_count < 2'd2);
  assign out_valid = (fifo_count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  encoder_fifo #(.W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .count     (fifo_count)
  );

  assign head         = fifo_entry_t'(head_bits);
  assign out_instr    = out_valid ? head.instr : '0;
  assign out_err      = out_valid && head.err;
  assign out_err_code = out_valid ? head.code : ERR_NONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (pop && head.err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports, one per line:
- clk  in  1  sole clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept request
- in_fmt  in  instr_format_t  format to pack (R, I, S, B, U, J, CSR_I)
- in_opcode  in  7  opcode field
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R only)
- in_csr  in  12  CSR address (CSR_I only)
- in_imm  in  32  immediate, two's complement; for CSR_I, zero-extended uimm
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts word
- out_instr  out  instr_t  encoded 32-bit instruction
- out_err  out  1  immediate not representable, or bad format
- out_err_code  out  2  00 none, 01 range, 10 misaligned, 11 bad format
- err_count  out  16  saturating count of erroneous words delivered

Function
REQ-002 SHALL be the inverse of the immediate extractor: each format packs in_imm into the same bit positions the extractor reads from (v1_f2.4).
REQ-003 SHALL pack as follows:
- I: imm[11:0]
- S: imm[11:5] / imm[4:0]
- B: imm[12], imm[10:5], imm[4:1], imm[11]
- U: imm[31:12]
- J: imm[20], imm[10:1], imm[11], imm[19:12]
- CSR_I: csr into [31:20], imm[4:0] into [19:15]
- R: funct7 / rs2 / rs1 / funct3 / rd
REQ-004 SHALL place opcode in [6:0] always; rd, rs1, rs2 and funct3 only where the format defines them.
REQ-005 SHALL flag range error (01) when in_imm is not representable:
- I and S: outside [-2048, 2047]
- B: outside [-4096, 4094]
- J: outside [-2^20, 2^20-2]
- U: imm[11:0] nonzero
- CSR_I: imm[31:5] nonzero
REQ-006 SHALL flag misaligned (10) for B and J when imm[0]=1.
REQ-007 SHALL flag bad format (11) for any in_fmt outside the seven listed and output out_instr=0.
REQ-008 SHALL apply error priority bad format > misaligned > range.
REQ-009 SHALL still emit the truncated encoding when out_err_code is 01 or 10.
REQ-010 SHALL encode combinationally at accept and push {instr, err, code} into a 2-entry FIFO; request accepted when in_valid&&in_ready.
REQ-011 SHALL drive in_ready = (FIFO count < 2), from registered state only, never from out_ready.
REQ-012 SHALL give latency: word accepted at edge N is on out_valid after edge N when the FIFO was empty.
REQ-013 SHALL sustain one word per cycle with out_ready held high.
REQ-014 SHALL keep out_valid and the head word stable until out_ready, and deliver words in order.
REQ-015 SHALL perform push and pop in the same cycle when 0 < count < 2; count is unchanged.
REQ-016 SHALL increment err_count on out_valid&&out_ready&&out_err, holding at 0xFFFF.

Reset
REQ-017 SHALL, on rstn low, asynchronously empty the FIFO and set out_valid=0, out_instr=0, out_err=0, out_err_code=00, err_count=0; in_ready=1 once count is 0.
REQ-018 SHALL discard words in flight at reset; none are delivered after rstn rises.

Structure
REQ-019 SHALL take instr_t, instr_format_t and a new err_code_t enum from the shared types package; the range limits are package constants.
REQ-020 SHALL implement the buffer as one sub-module, encoder_fifo (2-entry, parameterised width).

Verification
REQ-021 I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_instr 0x FFF00093, err 00, one cycle after accept.
REQ-022 B, opcode 0x63, rs1=rs2=0, imm=8 -> 0x00000463; imm=9 -> code 10; imm=4096 -> code 01.
REQ-023 U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7; J, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF; S, imm=2048 -> code 01.
REQ-024 out_ready=0, offer 3 requests -> 2 accepted, then in_ready=0; release -> all 3 out in order, no loss or duplication.
REQ-025 rstn pulsed low with 2 words queued -> out_valid=0 immediately, err_count=0, nothing delivered after release.
REQ-026 err_count preset to 0xFFFE via 2 forced errors -> stays 0xFFFF after further errors.
